// File: rtl/sistema_button_pkg.sv
// rtl/sistema_button_pkg.sv - shared constants for the push-button capture port
package sistema_button_pkg;

   localparam int ADDR_W = 2;

   localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

   localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/sistema_button_capture_if.sv
// rtl/sistema_button_capture_if.sv - Avalon-MM register bus plus interrupt line
interface sistema_button_capture_if;
   import sistema_button_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;

   modport master (output address, chipselect, write_n, writedata,
                   input  readdata, irq);
   modport slave  (input  address, chipselect, write_n, writedata,
                   output readdata, irq);
endinterface

// File: rtl/sistema_button_debounce.sv
// rtl/sistema_button_debounce.sv - one-bit two-flop synchroniser and stability debouncer
module sistema_button_debounce
   import sistema_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic stable_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A mismatch must persist DEBOUNCE_CYCLES samples in a row; any agreement restarts it.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= BTN_RELEASED;
         sync2_q  <= BTN_RELEASED;
         stable_q <= BTN_RELEASED;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/sistema_button_capture.sv
// rtl/sistema_button_capture.sv - debounced key input port with sticky edge capture and irq
// Define SISTEMA_BUTTON_BOTH_EDGES_EN to capture release edges as well as presses.
module sistema_button_capture
   import sistema_button_pkg::*;
#(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         button_in,
   sistema_button_capture_if.slave  bus
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] edge_evt;
   logic [31:0]      rdata;
   logic             wr;
   logic             unused_wd;

   for (genvar i = 0; i < WIDTH; i++) begin : g_key
      sistema_button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk      (clk),
         .reset    (reset),
         .btn_i    (button_in[i]),
         .stable_o (stable[i])
      );
   end

`ifdef SISTEMA_BUTTON_BOTH_EDGES_EN
   assign edge_evt = prev_q ^ stable;
`else
   assign edge_evt = prev_q & ~stable;
`endif

   assign wr        = bus.chipselect && !bus.write_n;
   assign unused_wd = ^bus.writedata;

   // Clear is applied before the OR so a same-cycle edge keeps the bit set.
   always_comb begin
      mask_d = mask_q;
      edge_d = edge_q;
      if (wr && bus.address == ADDR_MASK) begin
         mask_d = bus.writedata[WIDTH-1:0];
      end
      if (wr && bus.address == ADDR_EDGE) begin
         edge_d = edge_q & ~bus.writedata[WIDTH-1:0];
      end
      edge_d = edge_d | edge_evt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q <= {WIDTH{BTN_RELEASED}};
         mask_q <= '0;
         edge_q <= '0;
      end else begin
         prev_q <= stable;
         mask_q <= mask_d;
         edge_q <= edge_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (bus.address)
         ADDR_DATA: rdata[WIDTH-1:0] = stable;
         ADDR_RSVD: rdata            = '0;
         ADDR_MASK: rdata[WIDTH-1:0] = mask_q;
         ADDR_EDGE: rdata[WIDTH-1:0] = edge_q;
         default:   rdata            = '0;
      endcase
   end

   assign bus.readdata = rdata;
   assign bus.irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_sistema_button_capture.sv
// tb/tb_sistema_button_capture.sv - directed bench for sistema_button_capture (WIDTH=2, 4-cycle debounce)
module tb_sistema_button_capture;

`ifdef SISTEMA_BUTTON_BOTH_EDGES_EN
   localparam bit BOTH = 1'b1;
`else
   localparam bit BOTH = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] button_in;
   int         passed = 0;
   int         total  = 0;

   sistema_button_capture_if bus ();

   sistema_button_capture #(
      .WIDTH           (2),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .button_in (button_in),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      bus.address = a;
      #1;
      chk(tag, bus.readdata, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset          = 1'b1;
      button_in      = 2'b11;
      bus.address    = 2'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      tick(2);
      reset = 1'b0;
      tick(1);

      chk_rd("reset_data", 2'd0, 32'h3);
      chk_rd("reset_mask", 2'd2, 32'h0);
      chk_rd("reset_edge", 2'd3, 32'h0);
      chk("reset_irq", {31'd0, bus.irq}, 32'h0);

      button_in = 2'b10;
      tick(5);
      chk_rd("press_data_t5", 2'd0, 32'h3);
      tick(1);
      chk_rd("press_data_t6", 2'd0, 32'h2);
      chk_rd("press_edge_t6", 2'd3, 32'h0);
      tick(1);
      chk_rd("press_edge_t7", 2'd3, 32'h1);
      chk("press_irq_masked", {31'd0, bus.irq}, 32'h0);
      tick(13);

      button_in = 2'b00;
      tick(3);
      button_in = 2'b10;
      for (int i = 0; i < 8; i++) begin
         chk_rd("glitch_data", 2'd0, 32'h2);
         chk_rd("glitch_edge", 2'd3, 32'h1);
         tick(1);
      end

      wr(2'd2, 32'h1);
      chk("mask_irq_on", {31'd0, bus.irq}, 32'h1);
      chk_rd("mask_read", 2'd2, 32'h1);
      wr(2'd3, 32'h1);
      chk("clear_irq_off", {31'd0, bus.irq}, 32'h0);
      chk_rd("clear_edge", 2'd3, 32'h0);

      button_in = 2'b00;
      tick(6);
      chk_rd("setwins_data", 2'd0, 32'h0);
      wr(2'd3, 32'h2);
      chk_rd("setwins_edge", 2'd3, 32'h2);
      chk("setwins_irq_masked", {31'd0, bus.irq}, 32'h0);

      wr(2'd2, 32'hFFFF_FFFF);
      chk_rd("mask_upper_zero", 2'd2, 32'h3);
      chk("mask_late_irq", {31'd0, bus.irq}, 32'h1);
      wr(2'd0, 32'h3);
      chk_rd("data_ro", 2'd0, 32'h0);
      wr(2'd1, 32'hFFFF_FFFF);
      chk_rd("rsvd_zero", 2'd1, 32'h0);
      wr(2'd3, 32'h2);
      chk("clear2_irq_off", {31'd0, bus.irq}, 32'h0);

      button_in = 2'b01;
      tick(8);
      chk_rd("release0_data", 2'd0, 32'h1);
      chk_rd("release0_edge", 2'd3, BOTH ? 32'h1 : 32'h0);
      chk("release0_irq", {31'd0, bus.irq}, BOTH ? 32'h1 : 32'h0);
      wr(2'd3, 32'h3);
      button_in = 2'b11;
      tick(8);
      chk_rd("release1_data", 2'd0, 32'h3);
      chk_rd("release1_edge", 2'd3, BOTH ? 32'h2 : 32'h0);
      wr(2'd3, 32'h3);
      chk_rd("release_cleared", 2'd3, 32'h0);

      // Key held across a mid-debounce reset: a fresh full debounce must follow release.
      button_in = 2'b10;
      tick(4);
      #1 reset = 1'b1;
      chk_rd("async_rst_mask", 2'd2, 32'h0);
      chk_rd("async_rst_data", 2'd0, 32'h3);
      chk("async_rst_irq", {31'd0, bus.irq}, 32'h0);
      tick(2);
      reset = 1'b0;
      tick(5);
      chk_rd("rst_restart_t5", 2'd0, 32'h3);
      chk_rd("rst_no_edge", 2'd3, 32'h0);
      tick(1);
      chk_rd("rst_restart_t6", 2'd0, 32'h2);
      tick(1);
      chk_rd("rst_press_t7", 2'd3, 32'h1);
      chk("rst_irq_masked", {31'd0, bus.irq}, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
